regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter WordLen, default 32, data word width in bits.
REQ-002 Parameter AddrLen, default 5, register address width; register count Count = 2^AddrLen.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 validA  input  1  requester A has a pending write.
REQ-006 addrA  input  AddrLen  requester A destination register.
REQ-007 dataA  input  WordLen  requester A write data.
REQ-008 readyA  output  1  requester A accepted this cycle (handshake = validA & readyA).
REQ-009 validB, addrB, dataB, readyB: same as REQ-005..008 for requester B.
REQ-010 clearReq  input  1  single-cycle request to zero the whole register file.
REQ-011 busy  output  1  high while a clear sweep is in progress.
REQ-012 clearDone  output  1  one-cycle pulse when a clear sweep ends.
REQ-013 regWrite  output  1  write enable to the register file.
REQ-014 writeRegister  output  AddrLen  register file write address.
REQ-015 writeData  output  WordLen  register file write data.

Function
REQ-016 FSM states CLEAR and ARB; 5-bit-wide-or-wider sweep counter clrAddr (AddrLen bits); round-robin pointer lastGrant (A/B).
REQ-017 regWrite, writeRegister, writeData, clearDone are registered; busy, readyA, readyB are combinational from current state and inputs.
REQ-018 CLEAR: each cycle load regWrite=1, writeRegister=clrAddr, writeData=0; clrAddr increments; readyA=readyB=0; busy=1.
REQ-019 CLEAR sweep covers addresses 1..Count-1 exactly once, in ascending order (Count-1 consecutive write cycles); address 0 is never written.
REQ-020 CLEAR -> ARB on the cycle clrAddr==Count-1 is issued; clearDone=1 for the following cycle only.
REQ-021 clearReq during CLEAR is ignored.
REQ-022 ARB with clearReq=1: no grant that cycle (readyA=readyB=0), regWrite loads 0, clrAddr loads 1, next state CLEAR.
REQ-023 ARB, clearReq=0, only one valid: that requester gets ready=1.
REQ-024 ARB, both valid: grant the requester not equal to lastGrant; loser's ready=0.
REQ-025 lastGrant updates to the granted requester on every handshake; unchanged otherwise.
REQ-026 At most one of readyA/readyB is 1 in any cycle; ready is never 1 without matching valid.
REQ-027 Handshake in cycle n: regWrite=1, writeRegister=addr, writeData=data in cycle n+1 (latency 1).
REQ-028 Handshake with addr==0: accepted (ready=1, lastGrant updates) but regWrite loads 0 (write discarded).
REQ-029 No handshake and not in CLEAR: regWrite loads 0; writeRegister/writeData hold previous values.
REQ-030 Both requesters targeting the same address: serviced in grant order, one write per cycle; no merging.
REQ-031 Requesters keep valid/addr/data stable until handshake; arbiter behaviour with unstable requests is unspecified.

Reset
REQ-032 rst low, at any time including mid-sweep or mid-grant: state=CLEAR, clrAddr=1, lastGrant=B, regWrite=0, writeRegister=0, writeData=0, clearDone=0, immediately and asynchronously.
REQ-033 While rst low: busy=1, readyA=readyB=0.
REQ-034 After rst deasserts, a full sweep (REQ-018..020) runs before any request is granted; after the sweep, A wins the first contended grant.

Verification
REQ-035 Release reset, AddrLen=5 -> regWrite=1 for 31 cycles, writeRegister 1..31 ascending, writeData=0; busy=1 throughout; clearDone one pulse; then busy=0.
REQ-036 After sweep, validA=validB=1 held 4 cycles, addrA=3/dataA=0xAAAA0000, addrB=4/dataB=0xBBBB0000 -> grants A,B,A,B; writes reg3,reg4,reg3,reg4 one cycle after each grant.
REQ-037 validA only, addrA=0, dataA=0xFFFFFFFF -> readyA=1, regWrite stays 0 next cycle; then validA, addrA=7 -> regWrite=1, writeRegister=7 next cycle.
REQ-038 clearReq=1 with validA=1 in ARB -> readyA=0 that cycle; 31-cycle sweep follows; readyA=1 only after clearDone; clearReq pulsed mid-sweep has no effect.
REQ-039 rst pulsed low at sweep address 10 -> outputs zero asynchronously; sweep restarts from address 1 after release.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Funnels two write requesters (A and B) into the single write port of a
// register file, and can sweep the whole file to zero on request or after
// reset. Register 0 is treated as hard-wired zero: it is never written by
// the sweep, and requester writes that target it are accepted but dropped.
//
// Ports
//   clk            single clock, all state changes on its rising edge
//   rst            asynchronous, active-low reset
//   validA/B       requester has a pending write
//   addrA/B        requester destination register
//   dataA/B        requester write data
//   readyA/B       requester accepted this cycle (handshake = valid & ready)
//   clearReq       one-cycle request to zero the register file
//   busy           a clear sweep is in progress (requests are held off)
//   clearDone      one-cycle pulse in the cycle after the last sweep address
//   regWrite       register file write enable (registered)
//   writeRegister  register file write address (registered)
//   writeData      register file write data (registered)
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int WordLen = 32,
    parameter int AddrLen = 5
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               validA,
    input  logic [AddrLen-1:0] addrA,
    input  logic [WordLen-1:0] dataA,
    output logic               readyA,

    input  logic               validB,
    input  logic [AddrLen-1:0] addrB,
    input  logic [WordLen-1:0] dataB,
    output logic               readyB,

    input  logic               clearReq,
    output logic               busy,
    output logic               clearDone,

    output logic               regWrite,
    output logic [AddrLen-1:0] writeRegister,
    output logic [WordLen-1:0] writeData
);

    // The sweep starts at 1 (register 0 is never written) and ends at the
    // highest address, Count-1, which is the all-ones address.
    localparam logic [AddrLen-1:0] FirstAddr = AddrLen'(1);
    localparam logic [AddrLen-1:0] LastAddr  = {AddrLen{1'b1}};

    typedef enum logic {
        ST_CLEAR,
        ST_ARB
    } state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

    // State
    state_t               r_state;
    logic [AddrLen-1:0]   r_clr_addr;
    grant_t               r_last_grant;

    // Registered outputs
    logic                 r_reg_write;
    logic [AddrLen-1:0]   r_write_register;
    logic [WordLen-1:0]   r_write_data;
    logic                 r_clear_done;

    // Next-state values and grant decisions
    state_t               w_next_state;
    logic [AddrLen-1:0]   w_next_clr_addr;
    grant_t               w_next_last_grant;
    logic                 w_next_reg_write;
    logic [AddrLen-1:0]   w_next_write_register;
    logic [WordLen-1:0]   w_next_write_data;
    logic                 w_next_clear_done;
    logic                 w_grant_a;
    logic                 w_grant_b;

    // -------------------------------------------------------------------------
    // Next-state and grant logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through this block can leave one unassigned and infer a latch.
        w_next_state          = r_state;
        w_next_clr_addr       = r_clr_addr;
        w_next_last_grant     = r_last_grant;
        w_next_reg_write      = 1'b0;
        w_next_write_register = r_write_register;
        w_next_write_data     = r_write_data;
        w_next_clear_done     = 1'b0;
        w_grant_a             = 1'b0;
        w_grant_b             = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                // One zero write per cycle; clearReq is deliberately not
                // looked at here, so a request mid-sweep is ignored.
                w_next_reg_write      = 1'b1;
                w_next_write_register = r_clr_addr;
                w_next_write_data     = '0;
                w_next_clr_addr       = r_clr_addr + FirstAddr;
                if (r_clr_addr == LastAddr) begin
                    w_next_state      = ST_ARB;
                    w_next_clear_done = 1'b1;
                end
            end

            ST_ARB: begin
                if (clearReq) begin
                    // Clear wins over both requesters; nobody is granted in
                    // the cycle the sweep is launched.
                    w_next_clr_addr = FirstAddr;
                    w_next_state    = ST_CLEAR;
                end else begin
                    // Round robin: an uncontested requester always wins; on
                    // contention the one that did not win last time wins.
                    w_grant_a = validA && (!validB || (r_last_grant == GRANT_B));
                    w_grant_b = validB && (!validA || (r_last_grant == GRANT_A));

                    if (w_grant_a) begin
                        w_next_last_grant     = GRANT_A;
                        w_next_reg_write      = (addrA != '0);
                        w_next_write_register = addrA;
                        w_next_write_data     = dataA;
                    end else if (w_grant_b) begin
                        w_next_last_grant     = GRANT_B;
                        w_next_reg_write      = (addrB != '0);
                        w_next_write_register = addrB;
                        w_next_write_data     = dataB;
                    end
                end
            end

            default: begin
                w_next_state = ST_CLEAR;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // Reset lands in CLEAR with the sweep pointer at 1, so a full sweep runs
    // after every reset, and lastGrant=B so A wins the first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_CLEAR;
            r_clr_addr       <= FirstAddr;
            r_last_grant     <= GRANT_B;
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_clear_done     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the same pre-edge state.
            r_state          <= w_next_state;
            r_clr_addr       <= w_next_clr_addr;
            r_last_grant     <= w_next_last_grant;
            r_reg_write      <= w_next_reg_write;
            r_write_register <= w_next_write_register;
            r_write_data     <= w_next_write_data;
            r_clear_done     <= w_next_clear_done;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Reset forces r_state to CLEAR asynchronously, so busy goes high and
    // both readies drop immediately while rst is low.
    assign busy          = (r_state == ST_CLEAR);
    assign readyA        = w_grant_a;
    assign readyB        = w_grant_b;

    assign regWrite      = r_reg_write;
    assign writeRegister = r_write_register;
    assign writeData     = r_write_data;
    assign clearDone     = r_clear_done;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter (WordLen=32, AddrLen=5). Inputs
// are driven 1 ns after the rising edge; registered outputs are sampled at
// that point and combinational readies 1 ns later, after inputs settle.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          validA = 1'b0;
    logic [AW-1:0] addrA = '0;
    logic [DW-1:0] dataA = '0;
    logic          readyA;
    logic          validB = 1'b0;
    logic [AW-1:0] addrB = '0;
    logic [DW-1:0] dataB = '0;
    logic          readyB;
    logic          clearReq = 1'b0;
    logic          busy;
    logic          clearDone;
    logic          regWrite;
    logic [AW-1:0] writeRegister;
    logic [DW-1:0] writeData;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .WordLen(DW),
        .AddrLen(AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .validA       (validA),
        .addrA        (addrA),
        .dataA        (dataA),
        .readyA       (readyA),
        .validB       (validB),
        .addrB        (addrB),
        .dataB        (dataB),
        .readyB       (readyB),
        .clearReq     (clearReq),
        .busy         (busy),
        .clearDone    (clearDone),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks ready pattern now, then the registered write one cycle later.
    task automatic grant_and_write(input string tag, input logic exp_a, input logic exp_b,
                                   input logic exp_we, input logic [AW-1:0] exp_reg,
                                   input logic [DW-1:0] exp_dat);
        #1;
        compared++;
        if ({readyA, readyB} !== {exp_a, exp_b}) begin
            mismatched++;
            $display("FAIL %s_ready: got A=%b B=%b expected A=%b B=%b", tag, readyA, readyB, exp_a, exp_b);
        end
        tick();
        compared++;
        if ({regWrite, writeRegister, writeData} !== {exp_we, exp_reg, exp_dat}) begin
            mismatched++;
            $display("FAIL %s_write: got we=%b reg=%0d data=%h expected we=%b reg=%0d data=%h",
                     tag, regWrite, writeRegister, writeData, exp_we, exp_reg, exp_dat);
        end
    endtask

    // From a cycle where a sweep is already under way (or just starting),
    // checks the 31 ascending zero writes, the clearDone pulse, and that the
    // first grant (A expected) comes in the first cycle after the sweep.
    task automatic sweep_and_grant(input string tag, input int pulse_at,
                                   input logic [AW-1:0] exp_reg, input logic [DW-1:0] exp_dat);
        int next_addr   = 1;
        int done_pulses = 0;
        int done_at     = -1;
        int grant_at    = -1;
        for (int i = 0; i < 60; i++) begin
            clearReq = (i == pulse_at);
            #1;
            if (readyA || readyB) begin
                grant_at = i;
                compared++;
                if ({readyA, readyB, busy} !== 3'b100) begin
                    mismatched++;
                    $display("FAIL %s_grant: got A=%b B=%b busy=%b expected A=1 B=0 busy=0",
                             tag, readyA, readyB, busy);
                end
                tick();
                clearReq = 1'b0;
                validA   = 1'b0;
                validB   = 1'b0;
                compared++;
                if ({regWrite, writeRegister, writeData} !== {1'b1, exp_reg, exp_dat}) begin
                    mismatched++;
                    $display("FAIL %s_grant_write: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h",
                             tag, regWrite, writeRegister, writeData, exp_reg, exp_dat);
                end
                break;
            end
            tick();
            if (clearDone) begin
                done_pulses++;
                done_at = i;
            end
            if (regWrite) begin
                compared++;
                if ({writeRegister, writeData} !== {AW'(next_addr), {DW{1'b0}}}) begin
                    mismatched++;
                    $display("FAIL %s_sweep_write: got reg=%0d data=%h expected reg=%0d data=0",
                             tag, writeRegister, writeData, next_addr);
                end
                next_addr++;
            end
        end
        clearReq = 1'b0;
        compared++;
        if (next_addr !== 32) begin
            mismatched++;
            $display("FAIL %s_sweep_count: got %0d writes expected 31", tag, next_addr - 1);
        end
        compared++;
        if (done_pulses !== 1 || done_at !== 30) begin
            mismatched++;
            $display("FAIL %s_clear_done: got %0d pulses at cycle %0d expected 1 at cycle 30",
                     tag, done_pulses, done_at);
        end
        compared++;
        if (grant_at !== 31) begin
            mismatched++;
            $display("FAIL %s_grant_cycle: got %0d expected 31", tag, grant_at);
        end
    endtask

    task automatic test_reset();
        validA = 1'b1;
        addrA  = 5'd3;
        dataA  = 32'h1;
        #3 rst = 1'b0;
        #1;
        compared++;
        if ({regWrite, clearDone, busy, readyA, readyB, writeRegister, writeData} !==
            {5'b00100, {AW{1'b0}}, {DW{1'b0}}}) begin
            mismatched++;
            $display("FAIL reset_async: got we=%b done=%b busy=%b rA=%b rB=%b reg=%0d data=%h expected 0 0 1 0 0 0 0",
                     regWrite, clearDone, busy, readyA, readyB, writeRegister, writeData);
        end
        repeat (3) tick();
        compared++;
        if ({regWrite, clearDone, busy, readyA, readyB} !== 5'b00100) begin
            mismatched++;
            $display("FAIL reset_held: got we=%b done=%b busy=%b rA=%b rB=%b expected 0 0 1 0 0",
                     regWrite, clearDone, busy, readyA, readyB);
        end
        validA = 1'b0;
        rst    = 1'b1;
    endtask

    task automatic test_sweep();
        int next_addr   = 1;
        int busy_cycles = 0;
        int done_pulses = 0;
        int done_at     = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cycles++;
            tick();
            if (clearDone) begin
                done_pulses++;
                done_at = i;
            end
            if (regWrite) begin
                compared++;
                if ({writeRegister, writeData} !== {AW'(next_addr), {DW{1'b0}}}) begin
                    mismatched++;
                    $display("FAIL sweep_write: got reg=%0d data=%h expected reg=%0d data=0",
                             writeRegister, writeData, next_addr);
                end
                next_addr++;
            end
        end
        compared++;
        if (next_addr !== 32) begin
            mismatched++;
            $display("FAIL sweep_count: got %0d writes expected 31", next_addr - 1);
        end
        compared++;
        if (busy_cycles !== 31) begin
            mismatched++;
            $display("FAIL sweep_busy_cycles: got %0d expected 31", busy_cycles);
        end
        compared++;
        if (done_pulses !== 1 || done_at !== 30) begin
            mismatched++;
            $display("FAIL sweep_clear_done: got %0d pulses at cycle %0d expected 1 at cycle 30",
                     done_pulses, done_at);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL sweep_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_round_robin();
        validA = 1'b1; addrA = 5'd3; dataA = 32'hAAAA0000;
        validB = 1'b1; addrB = 5'd4; dataB = 32'hBBBB0000;
        grant_and_write("rr0", 1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA0000);
        grant_and_write("rr1", 1'b0, 1'b1, 1'b1, 5'd4, 32'hBBBB0000);
        grant_and_write("rr2", 1'b1, 1'b0, 1'b1, 5'd3, 32'hAAAA0000);
        grant_and_write("rr3", 1'b0, 1'b1, 1'b1, 5'd4, 32'hBBBB0000);
        validA = 1'b0;
        validB = 1'b0;
        // Idle cycle: no write, address and data hold their last values.
        grant_and_write("rr_idle", 1'b0, 1'b0, 1'b0, 5'd4, 32'hBBBB0000);
    endtask

    task automatic test_addr_zero();
        validA = 1'b1; addrA = 5'd0; dataA = 32'hFFFFFFFF;
        #1;
        compared++;
        if ({readyA, readyB} !== 2'b10) begin
            mismatched++;
            $display("FAIL zero_ready: got A=%b B=%b expected A=1 B=0", readyA, readyB);
        end
        tick();
        compared++;
        if (regWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_discard: got we=%b expected 0", regWrite);
        end
        addrA = 5'd7; dataA = 32'h12345678;
        grant_and_write("a_reg7", 1'b1, 1'b0, 1'b1, 5'd7, 32'h12345678);
        validA = 1'b0;
    endtask

    task automatic test_same_addr();
        // B alone wins even though lastGrant is A.
        validB = 1'b1; addrB = 5'd9; dataB = 32'h99;
        grant_and_write("b_only", 1'b0, 1'b1, 1'b1, 5'd9, 32'h99);
        // Both aimed at register 6: one write per cycle, in grant order.
        validA = 1'b1; addrA = 5'd6; dataA = 32'h6A;
        validB = 1'b1; addrB = 5'd6; dataB = 32'h6B;
        grant_and_write("same0", 1'b1, 1'b0, 1'b1, 5'd6, 32'h6A);
        dataA = 32'h7A;
        grant_and_write("same1", 1'b0, 1'b1, 1'b1, 5'd6, 32'h6B);
        validB = 1'b0;
        grant_and_write("same2", 1'b1, 1'b0, 1'b1, 5'd6, 32'h7A);
        validA = 1'b0;
    endtask

    task automatic test_clear_req();
        validA = 1'b1; addrA = 5'd5; dataA = 32'h55;
        clearReq = 1'b1;
        #1;
        compared++;
        if ({readyA, readyB, busy} !== 3'b000) begin
            mismatched++;
            $display("FAIL clear_req_ready: got A=%b B=%b busy=%b expected 0 0 0", readyA, readyB, busy);
        end
        tick();
        clearReq = 1'b0;
        compared++;
        if ({regWrite, busy} !== 2'b01) begin
            mismatched++;
            $display("FAIL clear_req_launch: got we=%b busy=%b expected we=0 busy=1", regWrite, busy);
        end
        sweep_and_grant("clear", 10, 5'd5, 32'h55);
    endtask

    task automatic test_reset_mid_sweep();
        clearReq = 1'b1;
        tick();
        clearReq = 1'b0;
        repeat (10) tick();
        compared++;
        if ({regWrite, writeRegister} !== {1'b1, 5'd10}) begin
            mismatched++;
            $display("FAIL mid_sweep_pos: got we=%b reg=%0d expected we=1 reg=10", regWrite, writeRegister);
        end
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({regWrite, clearDone, busy, writeRegister, writeData} !== {3'b001, {AW{1'b0}}, {DW{1'b0}}}) begin
            mismatched++;
            $display("FAIL mid_sweep_async: got we=%b done=%b busy=%b reg=%0d data=%h expected 0 0 1 0 0",
                     regWrite, clearDone, busy, writeRegister, writeData);
        end
        validA = 1'b1; addrA = 5'd12; dataA = 32'hC;
        validB = 1'b1; addrB = 5'd13; dataB = 32'hD;
        #1;
        compared++;
        if ({readyA, readyB} !== 2'b00) begin
            mismatched++;
            $display("FAIL mid_sweep_ready: got A=%b B=%b expected 0 0", readyA, readyB);
        end
        repeat (2) tick();
        rst = 1'b1;
        // lastGrant was A before reset; A winning here shows reset set it to B.
        sweep_and_grant("restart", -1, 5'd12, 32'hC);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_round_robin();
        test_addr_zero();
        test_same_addr();
        test_clear_req();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
